// File: rtl/timer_mmss.sv
// rtl/timer_mmss.sv - MM:SS BCD countdown timer fed by the keypad encoder
//
// Builds an MM:SS setpoint from encoder digits shifted in from the right,
// then counts down to 00:00 on 1 Hz ticks once countdown mode is selected.
//
// Optional feature macro: TIMER_ALARM_EN (expiry alarm held for ALARM_TICKS ticks).
//
// Parameters:
//   SYNC_STAGES  synchroniser depth for loadn / pgt_1hz (2..3)
//   ALARM_TICKS  ticks the alarm stays high after expiry (1..15)
//
// Ports:
//   clk        system clock
//   clearn     asynchronous active-low reset
//   bcd_input  BCD digit from the encoder
//   loadn      active-low digit-valid strobe (asynchronous to clk)
//   pgt_1hz    1 Hz pulse train (asynchronous to clk)
//   enablen    0 = entry mode, 1 = countdown mode
//   min_tens   minutes tens digit
//   min_ones   minutes ones digit
//   sec_tens   seconds tens digit
//   sec_ones   seconds ones digit
//   zero       all four digits are 0
//   alarm      expiry alarm (constant 0 without TIMER_ALARM_EN)

module timer_mmss #(
    parameter int SYNC_STAGES = 2,
    parameter int ALARM_TICKS = 3
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [3:0] bcd_input,
    input  logic       loadn,
    input  logic       pgt_1hz,
    input  logic       enablen,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       zero,
    output logic       alarm
);

    // Elaboration-time parameter range checks.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync_stages
        $error("timer_mmss: SYNC_STAGES must be 2..3");
    end
    if (ALARM_TICKS < 1 || ALARM_TICKS > 15) begin : g_bad_alarm_ticks
        $error("timer_mmss: ALARM_TICKS must be 1..15");
    end

    // ------------------------------------------------------------------
    // Input synchronisers and edge detectors
    // ------------------------------------------------------------------
    // Both chains reset to the idle level of their input so that leaving
    // reset with the strobes idle never manufactures a spurious event.
    logic [SYNC_STAGES-1:0] loadn_sync;
    logic [SYNC_STAGES-1:0] pgt_sync;
    logic                   loadn_hist;
    logic                   pgt_hist;
    logic                   loadn_s;
    logic                   pgt_s;
    logic                   load_evt;
    logic                   tick_evt;

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            loadn_sync <= '1;
            pgt_sync   <= '0;
            loadn_hist <= 1'b1;
            pgt_hist   <= 1'b0;
        end else begin
            loadn_sync <= {loadn_sync[SYNC_STAGES-2:0], loadn};
            pgt_sync   <= {pgt_sync[SYNC_STAGES-2:0], pgt_1hz};
            loadn_hist <= loadn_s;
            pgt_hist   <= pgt_s;
        end
    end

    assign loadn_s  = loadn_sync[SYNC_STAGES-1];
    assign pgt_s    = pgt_sync[SYNC_STAGES-1];

    // Single-clk event pulses: load on the falling strobe, tick on the
    // rising 1 Hz edge.
    assign load_evt = loadn_hist & ~loadn_s;
    assign tick_evt = pgt_s & ~pgt_hist;

    // ------------------------------------------------------------------
    // Event qualification by mode
    // ------------------------------------------------------------------
    logic digit_ok;
    logic do_shift;
    logic do_count;

    assign digit_ok = (bcd_input <= 4'd9);
    assign zero     = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                      (sec_tens == 4'd0) && (sec_ones == 4'd0);

    // Only the event belonging to the current mode acts; the other one is
    // simply dropped, which also resolves same-clk collisions.
    assign do_shift = ~enablen & load_evt & digit_ok;
    assign do_count =  enablen & tick_evt & ~zero;

    // ------------------------------------------------------------------
    // One-second decrement with BCD borrow
    // ------------------------------------------------------------------
    // Seconds tens above 5 (e.g. 01:90) is allowed: it counts down like
    // any other digit and only wraps to 5 when borrowing from 0.
    logic [3:0] dec_mt;
    logic [3:0] dec_mo;
    logic [3:0] dec_st;
    logic [3:0] dec_so;

    always_comb begin
        dec_mt = min_tens;
        dec_mo = min_ones;
        dec_st = sec_tens;
        dec_so = sec_ones - 4'd1;
        if (sec_ones == 4'd0) begin
            dec_so = 4'd9;
            if (sec_tens != 4'd0) begin
                dec_st = sec_tens - 4'd1;
            end else begin
                dec_st = 4'd5;
                if (min_ones != 4'd0) begin
                    dec_mo = min_ones - 4'd1;
                end else begin
                    // do_count guarantees zero=0, so min_tens is non-zero here.
                    dec_mo = 4'd9;
                    dec_mt = min_tens - 4'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
        end else if (do_shift) begin
            min_tens <= min_ones;
            min_ones <= sec_tens;
            sec_tens <= sec_ones;
            sec_ones <= bcd_input;
        end else if (do_count) begin
            min_tens <= dec_mt;
            min_ones <= dec_mo;
            sec_tens <= dec_st;
            sec_ones <= dec_so;
        end
    end

`ifdef TIMER_ALARM_EN
    // ------------------------------------------------------------------
    // Expiry alarm
    // ------------------------------------------------------------------
    // A counting tick can only land on 00:00 when it starts from 00:01,
    // so expiry is detected from the current digits rather than from the
    // decrement result.
    typedef enum logic {
        ALM_IDLE,
        ALM_RING
    } alm_state_t;

    alm_state_t alm_state;
    logic [3:0] alm_cnt;
    logic       expire;

    assign expire = do_count &&
                    (min_tens == 4'd0) && (min_ones == 4'd0) &&
                    (sec_tens == 4'd0) && (sec_ones == 4'd1);

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            alm_state <= ALM_IDLE;
            alm_cnt   <= 4'd0;
            alarm     <= 1'b0;
        end else if (load_evt) begin
            // Any load event, valid or not and in either mode, silences it.
            alm_state <= ALM_IDLE;
            alm_cnt   <= 4'd0;
            alarm     <= 1'b0;
        end else begin
            case (alm_state)
                ALM_IDLE: begin
                    if (expire) begin
                        alm_state <= ALM_RING;
                        alm_cnt   <= 4'(ALARM_TICKS);
                        alarm     <= 1'b1;
                    end
                end
                ALM_RING: begin
                    // Counter hitting 0 on a tick keeps the alarm up for
                    // that clk; it drops on the following one.
                    if (alm_cnt == 4'd0) begin
                        alm_state <= ALM_IDLE;
                        alarm     <= 1'b0;
                    end else if (tick_evt) begin
                        alm_cnt <= alm_cnt - 4'd1;
                    end
                end
                default: begin
                    alm_state <= ALM_IDLE;
                    alm_cnt   <= 4'd0;
                    alarm     <= 1'b0;
                end
            endcase
        end
    end
`else
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_timer_mmss.sv
// tb/tb_timer_mmss.sv - scoreboard bench for timer_mmss with a digit-value reference model

module tb_timer_mmss;

    localparam int SYNC_STAGES = 2;
    localparam int ALARM_TICKS = 3;
    localparam int LAT         = SYNC_STAGES + 1;

    logic       clk = 1'b0;
    logic       clearn;
    logic [3:0] bcd_input;
    logic       loadn;
    logic       pgt_1hz;
    logic       enablen;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       zero;
    logic       alarm;

    timer_mmss #(
        .SYNC_STAGES(SYNC_STAGES),
        .ALARM_TICKS(ALARM_TICKS)
    ) dut (
        .clk      (clk),
        .clearn   (clearn),
        .bcd_input(bcd_input),
        .loadn    (loadn),
        .pgt_1hz  (pgt_1hz),
        .enablen  (enablen),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .zero     (zero),
        .alarm    (alarm)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [17:0] exp;
        string       tag;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    // Reference model: the display as a 4-digit decimal number MMSS.
    int v       = 0;
    bit m_alarm = 1'b0;
    int m_cnt   = 0;

    function automatic logic [17:0] model_vec();
        logic [3:0] mt, mo, st, so;
        mt = 4'(v / 1000);
        mo = 4'((v / 100) % 10);
        st = 4'((v / 10) % 10);
        so = 4'(v % 10);
        return {mt, mo, st, so, (v == 0), m_alarm};
    endfunction

    task automatic check(input string tag, input logic [17:0] exp);
        logic [17:0] act;
        act = {min_tens, min_ones, sec_tens, sec_ones, zero, alarm};
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @cyc %0d: got %h%h:%h%h zero=%b alarm=%b, expected %h%h:%h%h zero=%b alarm=%b",
                     tag, cyc, act[17:14], act[13:10], act[9:6], act[5:2], act[1], act[0],
                     exp[17:14], exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic push(input int due, input string tag);
        sb_t e;
        e.due = due;
        e.exp = model_vec();
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic apply_model(input bit ld, input bit tk, input int d);
        int m, s;
        if (tk && m_alarm && m_cnt > 0) m_cnt--;
        if (!enablen) begin
            if (ld && d <= 9) v = (v * 10 + d) % 10000;
        end else if (tk && v != 0) begin
            m = v / 100;
            s = v % 100;
            if (s > 0) begin
                s--;
            end else begin
                s = 59;
                m--;
            end
            v = m * 100 + s;
`ifdef TIMER_ALARM_EN
            if (v == 0) begin
                m_alarm = 1'b1;
                m_cnt   = ALARM_TICKS;
            end
`endif
        end
        if (ld) m_alarm = 1'b0;
    endtask

    // Issue one strobe/tick (or both); expect old state one clk before the
    // synchronised event lands and new state exactly LAT clks after issue.
    task automatic op(input bit ld, input bit tk, input logic [3:0] d, input string tag);
        @(posedge clk); #1;
        push(cyc + LAT - 1, {tag, "_pre"});
        apply_model(ld, tk, int'(d));
        push(cyc + LAT, {tag, "_post"});
        if (m_alarm && m_cnt == 0) m_alarm = 1'b0;
        bcd_input = d;
        if (ld) loadn = 1'b0;
        if (tk) pgt_1hz = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        loadn   = 1'b1;
        pgt_1hz = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic set_mode(input logic en);
        @(posedge clk); #1;
        enablen = en;
        push(cyc + 1, "mode_retain");
        repeat (2) @(posedge clk);
    endtask

    task automatic load4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        op(1'b1, 1'b0, a, "entry");
        op(1'b1, 1'b0, b, "entry");
        op(1'b1, 1'b0, c, "entry");
        op(1'b1, 1'b0, d, "entry");
    endtask

    always @(negedge clk) begin : monitor
        sb_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check(e.tag, e.exp);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clearn    = 1'b0;
        loadn     = 1'b1;
        pgt_1hz   = 1'b0;
        enablen   = 1'b0;
        bcd_input = 4'd0;
        #2;
        check("reset_async", {16'h0000, 1'b1, 1'b0});
        @(posedge clk); #1;
        clearn = 1'b1;
        repeat (3) @(posedge clk);

        // Entry, invalid digit, ticks ignored in entry mode
        load4(4'd1, 4'd2, 4'd3, 4'd0);
        op(1'b1, 1'b0, 4'hC, "bad_digit");
        op(1'b0, 1'b1, 4'd0, "entry_tick");

        // Borrow chain 10:00 -> 09:59
        load4(4'd1, 4'd0, 4'd0, 4'd0);
        set_mode(1'b1);
        op(1'b0, 1'b1, 4'd0, "borrow");

        // 00:01 -> 00:00, then hold at zero (alarm counts down if enabled)
        set_mode(1'b0);
        load4(4'd0, 4'd0, 4'd0, 4'd1);
        set_mode(1'b1);
        op(1'b0, 1'b1, 4'd0, "to_zero");
        repeat (4) op(1'b0, 1'b1, 4'd0, "hold_zero");

        // Non-normal seconds 01:90 down through 01:00 to 00:59
        set_mode(1'b0);
        load4(4'd0, 4'd1, 4'd9, 4'd0);
        set_mode(1'b1);
        repeat (91) op(1'b0, 1'b1, 4'd0, "countdown");

        // Load strobe during countdown, and load/tick collision
        op(1'b1, 1'b0, 4'd7, "load_in_countdown");
        op(1'b1, 1'b1, 4'd7, "collision_count");
        set_mode(1'b0);
        op(1'b1, 1'b1, 4'd3, "collision_entry");

        // Alarm raised then cleared by a load strobe while ringing
        load4(4'd0, 4'd0, 4'd0, 4'd1);
        set_mode(1'b1);
        op(1'b0, 1'b1, 4'd0, "expire");
        op(1'b0, 1'b1, 4'd0, "ringing");
        op(1'b1, 1'b0, 4'd0, "alarm_clear");

        for (int i = 0; i < 300; i++) begin
            int         k;
            logic [3:0] d;
            k = $urandom_range(0, 9);
            d = 4'($urandom_range(0, 11));
            if (k < 4)       op(1'b1, 1'b0, d, "rnd_load");
            else if (k < 8)  op(1'b0, 1'b1, d, "rnd_tick");
            else if (k == 8) op(1'b1, 1'b1, d, "rnd_both");
            else             set_mode(~enablen);
        end

        // Reset in the middle of a countdown, between clock edges
        set_mode(1'b0);
        load4(4'd5, 4'd5, 4'd5, 4'd5);
        set_mode(1'b1);
        op(1'b0, 1'b1, 4'd0, "pre_reset_tick");
        @(posedge clk); #3;
        clearn = 1'b0;
        #1;
        check("reset_mid_count", {16'h0000, 1'b1, 1'b0});
        v       = 0;
        m_alarm = 1'b0;
        m_cnt   = 0;
        @(posedge clk); #1;
        clearn  = 1'b1;
        enablen = 1'b0;
        op(1'b1, 1'b0, 4'd4, "after_reset");

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries pending, expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/timer_mmss.md
Name: timer_mmss

Overview:
- Countdown timer stage directly downstream of the keypad encoder in the microwave datapath.
- Consumes the encoder's BCD digit, its active-low digit strobe and the 1 Hz pulse train.
- Builds an MM:SS setpoint by shifting digits in from the right, then counts down to 00:00 once cooking starts.
- Drives four BCD digits to the display decoders and a zero flag to the control FSM.

Parameters:
- SYNC_STAGES, 2: flip-flop stages synchronising loadn and pgt_1hz into clk; legal 2..3.
- ALARM_TICKS, 3: number of pgt_1hz ticks the alarm stays high after expiry (used only with the optional feature); legal 1..15.

Ports:
- clk  input  1  system clock.
- clearn  input  1  asynchronous active-low reset.
- bcd_input  input  4  BCD digit from the encoder.
- loadn  input  1  active-low digit-valid strobe from the encoder.
- pgt_1hz  input  1  1 Hz pulse train from the encoder, asynchronous to clk.
- enablen  input  1  low = entry mode, high = countdown mode.
- min_tens  output  4  minutes tens digit.
- min_ones  output  4  minutes ones digit.
- sec_tens  output  4  seconds tens digit.
- sec_ones  output  4  seconds ones digit.
- zero  output  1  high when all four digits are 0.
- alarm  output  1  expiry alarm; tied 0 unless TIMER_ALARM_EN.

Behaviour:
- Reset (clearn low, async): all digits 0, zero=1, alarm=0, synchroniser and edge-detect flops cleared to the idle level (loadn=1, pgt_1hz=0).
- Synchronisation: loadn and pgt_1hz each pass through SYNC_STAGES flops, then one history flop for edge detection.
- Load event: falling edge of the synchronised loadn.
- Tick event: rising edge of the synchronised pgt_1hz.
- Each event lasts exactly one clk.
- Input-to-register latency is SYNC_STAGES+1 clk.
- Entry mode (enablen=0):
  - A load event with bcd_input<=9 shifts left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=bcd_input.
  - A load event with bcd_input>9 is ignored.
  - Tick events are ignored.
- Countdown mode (enablen=1):
  - Load events are ignored.
  - A tick event with zero=0 decrements MM:SS by one second.
    - sec_ones>0: sec_ones-1.
    - Else sec_ones=9 and sec_tens decrements.
    - If sec_tens was 0, it wraps to 5 and the minutes borrow.
    - min_ones borrows from min_tens in the same way, wrapping 0->9.
  - A tick event with zero=1 holds all digits (no wrap to 99:59).
- Seconds tens >5 is legal when entered (e.g. 01:90). It counts down normally to 0 and only then wraps to 5.
- zero is combinational from the digit registers.
- Simultaneous load and tick events in the same clk: only the event valid for the current mode acts; the other is dropped.
- Mode change mid-operation: digits are retained; no event is generated by the enablen edge itself.
- Reset mid-countdown clears all digits immediately, regardless of clk.

Optional Feature:
- Macro: TIMER_ALARM_EN.
- Defined:
  - A countdown tick that makes zero go 0->1 sets alarm=1 and loads a 4-bit alarm counter with ALARM_TICKS.
  - Each subsequent tick event decrements the counter, regardless of mode.
  - alarm drops in the clk after the counter reaches 0.
  - Any load event or clearn clears alarm immediately.
- Undefined: alarm is constant 0 and no alarm counter logic exists.

Test Plan:
- Reset: clearn=0 asynchronously mid-cycle -> all digits 0, zero=1, alarm=0 without waiting for a clk edge.
- Entry: enablen=0, strobe digits 1,2,3,0 on loadn -> 12:30, zero=0; strobe bcd_input=4'hC -> still 12:30; tick events during entry -> no change.
- Borrow chain: load 10:00, enablen=1, one tick -> 09:59. Load 00:01, one tick -> 00:00 with zero=1; further ticks -> stays 00:00.
- Non-normal seconds: load 01:90, enablen=1, ten ticks -> 01:80; 90 ticks from 01:90 -> 01:00; next tick -> 00:59.
- Latency/collision: pgt_1hz rising -> decrement visible exactly SYNC_STAGES+1 clk later. Load strobe during countdown -> digits unchanged.
- TIMER_ALARM_EN, ALARM_TICKS=3: count 00:01 to 00:00 -> alarm high for 3 further ticks then low. Repeat and strobe loadn while alarm=1 -> alarm clears immediately.
